alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU placed directly downstream of the ALU control decoder.
- Consumes the 4-bit alucontrol code plus two 64-bit operands and produces a registered 64-bit result and a zero flag for the CBZ branch logic.
- Uses a valid/ready handshake on both sides, so the datapath can be re-timed toward a multi-cycle core.
- Optionally adds an iterative multiply.

Parameters:
- N, 64, operand/result width in bits (must be ≥8 and even).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and alucontrol presented
- in_ready  out  1  unit can accept a new operation
- alucontrol  in  4  operation code from the ALU control decoder
- a  in  N  operand A
- b  in  N  operand B
- out_valid  out  1  result/zero are valid
- out_ready  in  1  consumer accepts the result
- result  out  N  operation result
- zero  out  1  result == 0
- busy  out  1  multi-cycle operation in progress

Behaviour:
- Codes:
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b, mod 2^N
  - 0110 SUB: a − b, two's complement, mod 2^N
  - 0111 PASS_B: b
  - 1000 MUL: optional feature, see below
  - Any other code: result 0, zero 1. Not an error.
- Reset (reset=0, asynchronous) forces:
  - state=IDLE
  - out_valid=0, result=0, zero=0, busy=0
  - in_ready=1 once reset is released
  - Reset mid-operation discards the operation; no output is ever produced for it.
- FSM states: IDLE, BUSY, HOLD.
- IDLE:
  - in_ready=1.
  - Transfer occurs when in_valid & in_ready.
  - Single-cycle code: result/zero registered at that edge, out_valid=1 the next cycle (latency 1), go to HOLD.
  - MUL code: go to BUSY.
- HOLD:
  - out_valid=1; result and zero held stable until out_ready=1.
  - in_ready = out_ready (pass-through), so back-to-back transfers give one result per cycle.
  - On out_ready & in_valid: accept the new operation in the same edge. Single-cycle op → stay in HOLD with the new result. MUL → BUSY.
  - On out_ready & !in_valid: go to IDLE, out_valid=0.
- BUSY:
  - in_ready=0, busy=1, out_valid=0.
  - Iterates as described under Optional Feature, then goes to HOLD.
- Handshake rules:
  - Inputs are sampled only on the transfer edge; a, b and alucontrol may change freely at other times.
  - Dropping in_valid without a transfer is legal.
- zero is computed from the registered result in the same cycle it is registered, so it is always consistent with result.
- No flags other than zero. Carry and overflow are discarded.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Code 1000 runs a shift-add multiply giving the low N bits of a*b (unsigned; identical to signed for the low half).
  - Uses an internal counter 0..N−1 and one bit of b per cycle.
  - Exactly N cycles in BUSY, so out_valid rises N+1 cycles after the transfer edge.
  - Multiplicand and multiplier are latched at transfer.
- Undefined:
  - Code 1000 is treated as an undefined code: result 0, zero 1, latency 1.
  - BUSY is unreachable and busy is tied to 0.

Test Plan:
- Reset: hold reset=0 with in_valid=1 → out_valid=0, result=0, busy=0. Release reset → in_ready=1.
- Single-cycle ops, out_ready=1: ADD a=5,b=7 → result 12, zero 0. SUB 7−7 → 0, zero 1. SUB 0−1 → all-ones. AND 0xF0&0x3C → 0x30. OR → 0xFC. PASS_B b=0 → 0, zero 1. Each result appears 1 cycle after transfer.
- Back-pressure: ADD 1+2 with out_ready=0 for 3 cycles → result 3 held, in_ready=0. Then out_ready=1 with a queued SUB 9−4 → 5 next cycle, no loss or duplication.
- Back-to-back streaming: 8 random ops with in_valid=out_ready=1 → 8 results in 8 consecutive cycles, in order, matching the reference model.
- Undefined code 1111 with a=b=all-ones → result 0, zero 1.
- ALU_MUL_EN defined:
  - 3*5 → 15 after exactly N+1 cycles, busy=1 throughout, in_ready=0.
  - (2^32)*(2^32) with N=64 → 0, zero 1.
  - Assert reset=0 mid-BUSY → no output after reset is released.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops: AND, OR, ADD, SUB, PASS_B. Undefined codes give result 0, zero 1.
// Optional iterative shift-add multiply (code 1000) is enabled by defining ALU_MUL_EN.
// Without ALU_MUL_EN, code 1000 behaves as an undefined code and busy is tied low.
module alu_exec_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alucontrol,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Single-cycle operations; anything unrecognised yields zero.
    function automatic logic [N-1:0] alu_calc(input logic [3:0] op,
                                              input logic [N-1:0] x,
                                              input logic [N-1:0] y);
        logic [N-1:0] r;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_PASS: r = y;
            default: r = {N{1'b0}};
        endcase
        return r;
    endfunction

    // Zero-detect helper shared by the single-cycle and multiply paths.
    function automatic logic is_zero(input logic [N-1:0] v);
        return (v == {N{1'b0}});
    endfunction

    state_t       state_r;
    logic         out_valid_r;
    logic [N-1:0] result_r;
    logic         zero_r;
    logic         in_ready_s;
    logic         take_s;
    logic         is_mul_s;
    logic [N-1:0] calc_s;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic          busy_r;
    logic [N-1:0]  mcand_r;
    logic [N-1:0]  mplier_r;
    logic [N-1:0]  acc_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  partial_s;

    assign is_mul_s  = (alucontrol == OP_MUL);
    assign partial_s = acc_r + (mplier_r[0] ? mcand_r : {N{1'b0}});
    assign busy      = busy_r;
`else
    assign is_mul_s  = 1'b0;
    assign busy      = 1'b0;
`endif

    assign calc_s    = alu_calc(alucontrol, a, b);
    assign take_s    = in_valid & in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;

    // Accept in IDLE, or in HOLD when the consumer drains the current result this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (!reset) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                HOLD:    in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    // Control FSM with registered result, zero, out_valid and busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {N{1'b0}};
            zero_r      <= 1'b0;
`ifdef ALU_MUL_EN
            busy_r      <= 1'b0;
            mcand_r     <= {N{1'b0}};
            mplier_r    <= {N{1'b0}};
            acc_r       <= {N{1'b0}};
            cnt_r       <= {CW{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE, HOLD: begin
                    if (take_s) begin
                        if (is_mul_s) begin
                            state_r     <= BUSY;
                            out_valid_r <= 1'b0;
`ifdef ALU_MUL_EN
                            busy_r      <= 1'b1;
                            mcand_r     <= a;
                            mplier_r    <= b;
                            acc_r       <= {N{1'b0}};
                            cnt_r       <= {CW{1'b0}};
`endif
                        end else begin
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                            result_r    <= calc_s;
                            zero_r      <= is_zero(calc_s);
                        end
                    end else if ((state_r == HOLD) && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                    end
                end
                BUSY: begin
`ifdef ALU_MUL_EN
                    // One multiplier bit per cycle; the last step writes the result directly.
                    acc_r    <= partial_s;
                    mcand_r  <= mcand_r << 1'b1;
                    mplier_r <= mplier_r >> 1'b1;
                    cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= HOLD;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        result_r    <= partial_s;
                        zero_r      <= is_zero(partial_s);
                    end else begin
                        state_r     <= BUSY;
                    end
`else
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
`endif
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake sequences,
// and a randomized run against a plain-arithmetic reference model.
// Honours ALU_MUL_EN in the same way as the design.
module tb_alu_exec_unit;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alucontrol = 4'd0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         zero;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alucontrol(alucontrol), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the specification's operation table as plain arithmetic.
    function automatic logic [N-1:0] ref_calc(input logic [3:0] op, input logic [N-1:0] x,
                                              input logic [N-1:0] y);
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return y;
`ifdef ALU_MUL_EN
            4'b1000: return x * y;
`endif
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] q_exp[$];
    logic [3:0]   ops_pool[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0011, 4'b1111, 4'b1000};

    initial begin
        logic [N-1:0] all1;
        logic [N-1:0] exp_v;
        logic [N-1:0] p32;
        logic [3:0]   op_v;
        logic         fire_in;
        logic         seen;
        int           lat;
        int           n_out;
        int           mul_lat;

        all1 = '1;
        p32  = 64'h0000_0001_0000_0000;
`ifdef ALU_MUL_EN
        mul_lat = N + 1;
`else
        mul_lat = 1;
`endif

        // Reset held low while operands are presented.
        in_valid = 1'b1; alucontrol = 4'b0010; a = 64'd1; b = 64'd1; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();

        // Directed vectors.
        vecs.push_back('{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1});
        vecs.push_back('{4'b0110, 64'd7, 64'd7, 64'd0, 1'b1, 1});
        vecs.push_back('{4'b0110, 64'd0, 64'd1, all1, 1'b0, 1});
        vecs.push_back('{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1});
        vecs.push_back('{4'b0001, 64'hF0, 64'h3C, 64'hFC, 1'b0, 1});
        vecs.push_back('{4'b0111, 64'd99, 64'd0, 64'd0, 1'b1, 1});
        vecs.push_back('{4'b1111, all1, all1, 64'd0, 1'b1, 1});
        vecs.push_back('{4'b0010, all1, 64'd1, 64'd0, 1'b1, 1});
`ifdef ALU_MUL_EN
        vecs.push_back('{4'b1000, 64'd3, 64'd5, 64'd15, 1'b0, N + 1});
        vecs.push_back('{4'b1000, p32, p32, 64'd0, 1'b1, N + 1});
        vecs.push_back('{4'b1000, all1, all1, 64'd1, 1'b0, N + 1});
`else
        vecs.push_back('{4'b1000, 64'd3, 64'd5, 64'd0, 1'b1, 1});
`endif
        foreach (vecs[i]) begin
            alucontrol = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0; a = $urandom; b = $urandom; alucontrol = 4'b0010;
            lat = 1;
            while (!out_valid && lat < N + 20) begin
                chk($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd1);
                chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].z});
            tick();
            chk($sformatf("v%0d_drained", i), {63'd0, out_valid}, 64'd0);
        end

        // Back-pressure: result held while out_ready is low, queued op accepted afterwards.
        alucontrol = 4'b0010; a = 64'd1; b = 64'd2; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        alucontrol = 4'b0110; a = 64'd9; b = 64'd4;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", result, 64'd3);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_passthru_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_next_result", result, 64'd5);
        tick();
        chk("bp_idle", {63'd0, out_valid}, 64'd0);

        // Back-to-back streaming of 8 single-cycle ops, one result per cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            alucontrol = ops_pool[$urandom_range(0, 6)];
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = a;
            exp_v = ref_calc(alucontrol, a, b);
            in_valid = 1'b1;
            tick();
            chk($sformatf("stream%0d_valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("stream%0d_result", k), result, exp_v);
            chk($sformatf("stream%0d_zero", k), {63'd0, zero}, {63'd0, (exp_v == '0)});
        end
        in_valid = 1'b0;
        tick();

`ifdef ALU_MUL_EN
        // Reset asserted mid-multiply discards the operation.
        alucontrol = 4'b1000; a = 64'd3; b = 64'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (N + 10) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("mid_rst_no_output", {63'd0, seen}, 64'd0);
`endif

        // Randomized handshake traffic against the reference model queue.
        n_out = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            op_v       = ops_pool[$urandom_range(0, 7)];
            alucontrol = op_v;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) b = a;
            #1;
            fire_in = in_valid & in_ready;
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("rand_unexpected_output", 64'd1, 64'd0);
                end else begin
                    exp_v = q_exp.pop_front();
                    chk("rand_result", result, exp_v);
                    chk("rand_zero", {63'd0, zero}, {63'd0, (exp_v == '0)});
                    n_out++;
                end
            end
            exp_v = ref_calc(op_v, a, b);
            tick();
            if (fire_in) q_exp.push_back(exp_v);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3 * N && q_exp.size() != 0; c++) begin
            if (out_valid) begin
                exp_v = q_exp.pop_front();
                chk("drain_result", result, exp_v);
                n_out++;
            end
            tick();
        end
        chk("drain_queue_empty", 64'(q_exp.size()), 64'd0);
        chk("rand_enough_results", 64'(n_out >= 30), 64'd1);
        chk("final_mul_lat_cfg", 64'(mul_lat), 64'(vecs[8].lat));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
